// File: rtl/aes_apb_sequencer.sv
// aes_apb_sequencer: APB master streaming 128-bit blocks through the aes_ip data registers,
// paced per block and direction by the core's dma_req lines.
module aes_apb_sequencer #(
    parameter logic [31:0] DIN_ADDR  = 32'h0000_0008,
    parameter logic [31:0] DOUT_ADDR = 32'h0000_000C
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_nblocks,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    input  logic [1:0]  dma_req,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    output logic        done,
    output logic        err
);
    typedef enum logic [3:0] {
        IDLE, WAIT_WR, WR_FETCH, WR_SETUP, WR_ACCESS,
        WAIT_RD, RD_SETUP, RD_ACCESS, RD_PUSH, DONE
    } state_t;

    state_t      state, nxt;
    logic [15:0] blk_cnt;
    logic [1:0]  word_idx;
    logic [31:0] wdata, rdata;
    logic        abort_pend;

    logic acc, fin, last, accept;
    assign acc    = state == WR_ACCESS || state == RD_ACCESS;
    // An abort seen in a SETUP cycle is remembered so the transfer still completes legally.
    assign fin    = acc && PREADY && (PSLVERR || abort || abort_pend);
    assign last   = word_idx == 2'd3;
    assign accept = state == IDLE && cmd_valid && cmd_ready;
    assign PWDATA   = wdata;
    assign out_data = rdata;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = !accept ? IDLE : cmd_nblocks == 16'd0 ? DONE : WAIT_WR;
            WAIT_WR:   nxt = abort ? DONE : dma_req[1] ? WR_FETCH : WAIT_WR;
            WR_FETCH:  nxt = abort ? DONE : in_valid ? WR_SETUP : WR_FETCH;
            WR_SETUP:  nxt = WR_ACCESS;
            WR_ACCESS: nxt = !PREADY ? WR_ACCESS : fin ? DONE : last ? WAIT_RD : WR_FETCH;
            WAIT_RD:   nxt = abort ? DONE : dma_req[0] ? RD_SETUP : WAIT_RD;
            RD_SETUP:  nxt = RD_ACCESS;
            RD_ACCESS: nxt = !PREADY ? RD_ACCESS : fin ? DONE : RD_PUSH;
            RD_PUSH:   nxt = abort ? DONE : !out_ready ? RD_PUSH : !last ? RD_SETUP :
                             blk_cnt == 16'd1 ? DONE : WAIT_WR;
            DONE:      nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            blk_cnt    <= '0;
            word_idx   <= '0;
            wdata      <= '0;
            rdata      <= '0;
            abort_pend <= 1'b0;
        end else begin
            state      <= nxt;
            cmd_ready  <= nxt == IDLE;
            in_ready   <= nxt == WR_FETCH;
            out_valid  <= nxt == RD_PUSH;
            PSEL       <= nxt inside {WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS};
            PENABLE    <= nxt inside {WR_ACCESS, RD_ACCESS};
            done       <= nxt == DONE;
            abort_pend <= (state == IDLE || state == DONE) ? 1'b0 : abort_pend | abort;
            if (nxt == WR_SETUP) begin
                PADDR  <= DIN_ADDR;
                PWRITE <= 1'b1;
            end
            if (nxt == RD_SETUP) begin
                PADDR  <= DOUT_ADDR;
                PWRITE <= 1'b0;
            end
            if (accept) begin
                blk_cnt  <= cmd_nblocks;
                err      <= 1'b0;
                word_idx <= '0;
            end
            if (state == WR_FETCH && in_valid)
                wdata <= in_data;
            if (acc && PREADY && PSLVERR)
                err <= 1'b1;
            if (state == WR_ACCESS && PREADY && !fin)
                word_idx <= word_idx + 2'd1;
            if (state == RD_ACCESS && PREADY && !PSLVERR)
                rdata <= PRDATA;
            if (state == RD_PUSH && out_ready && !abort) begin
                word_idx <= word_idx + 2'd1;
                if (last)
                    blk_cnt <= blk_cnt - 16'd1;
            end
        end
    end
endmodule
